mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all address ports.
REQ-002 Parameter LINE_W, default 128, cache-line width of all data ports.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 ic_req  input  1  icache line-fill request; held high until ic_gnt is seen.
REQ-006 ic_addr  input  ADDR_W  icache fill address; valid while ic_req is high.
REQ-007 ic_gnt  output  1  one-cycle pulse: icache request accepted.
REQ-008 ic_rvalid  output  1  one-cycle pulse: ic_rdata valid.
REQ-009 ic_rdata  output  LINE_W  returned icache line.
REQ-010 dc_req  input  1  dcache fill/writeback request; held high until dc_gnt is seen.
REQ-011 dc_we  input  1  1 = writeback, 0 = fill; valid with dc_req.
REQ-012 dc_addr  input  ADDR_W  dcache address.
REQ-013 dc_wdata  input  LINE_W  writeback line.
REQ-014 dc_gnt  output  1  one-cycle pulse: dcache request accepted.
REQ-015 dc_rvalid  output  1  one-cycle pulse: dcache completion (fill data or write ack).
REQ-016 dc_rdata  output  LINE_W  returned dcache line.
REQ-017 mem_req  output  1  memory transaction active; held until mem_ready is sampled.
REQ-018 mem_we  output  1  write transaction.
REQ-019 mem_addr  output  ADDR_W  registered transaction address.
REQ-020 mem_wdata  output  LINE_W  registered write data.
REQ-021 mem_ready  input  1  one-cycle completion from memory; mem_rdata valid in the same cycle.
REQ-022 mem_rdata  input  LINE_W  memory read data.
REQ-023 busy  output  1  high whenever the state is not IDLE.

Function
REQ-024 FSM states: IDLE, BUSY_IC, BUSY_DC; all outputs are registered.
REQ-025 IDLE: if any request is sampled at an edge, latch the winner's addr/we/wdata into mem_addr/mem_we/mem_wdata and enter BUSY_IC or BUSY_DC.
REQ-026 In the first BUSY cycle, pulse the winner's gnt for exactly one cycle; mem_req is high from that cycle onward.
REQ-027 ic transactions force mem_we=0; mem_wdata is don't-care for reads.
REQ-028 BUSY_x with mem_ready sampled high: pulse x_rvalid the next cycle, drop mem_req that cycle, and return to IDLE.
REQ-029 Fill data: x_rdata is captured from mem_rdata. Writeback: dc_rdata is driven to 0 with the dc_rvalid pulse.
REQ-030 x_rdata holds its value until the next x_rvalid.
REQ-031 Latency: req first high in cycle N, mem_ready in cycle M (M >= N+1) -> rvalid in cycle M+1.
REQ-032 The minimum request-to-request turnaround includes one IDLE cycle; no back-to-back grant directly from BUSY.
REQ-033 Arbitration when both requests are sampled in IDLE is set by REQ-039/REQ-040. A single requester always wins.
REQ-034 mem_ready sampled in IDLE is ignored: no rvalid, no state change.
REQ-035 A request deasserted before its grant is dropped silently. The losing request stays pending and is arbitrated at the next IDLE.
REQ-036 ic_gnt and dc_gnt are never high together; ic_rvalid and dc_rvalid are never high together; at most one transaction is outstanding.

Reset
REQ-037 Reset sampled high: next cycle state=IDLE; mem_req, mem_we, ic_gnt, dc_gnt, ic_rvalid, dc_rvalid and busy = 0; mem_addr, mem_wdata, ic_rdata and dc_rdata = 0; round-robin pointer = IC-last.
REQ-038 Reset mid-transaction aborts it: no rvalid is issued for the aborted request, and a mem_ready arriving afterwards is ignored per REQ-034.

Configuration
REQ-039 Macro MEM_ARB_RR_EN undefined: fixed priority, dcache wins simultaneous requests, because a data stall already freezes the whole pipe.
REQ-040 Macro MEM_ARB_RR_EN defined: round-robin on simultaneous requests.
- A 1-bit last-owner register is updated at each grant.
- The requester not served last wins.
- After reset, dcache wins the first tie.

Verification
REQ-041 Single ic fill.
- Stimulus: ic_req=1 at cycle 0 with ic_addr=0x0000_1000; mem_ready at cycle 3 with mem_rdata=0xA5...A5.
- Response: ic_gnt at cycle 1; mem_req high cycles 1-3 with mem_addr=0x1000 and mem_we=0; ic_rvalid at cycle 4 with ic_rdata=0xA5...A5.
REQ-042 dc writeback.
- Stimulus: dc_req=1, dc_we=1, dc_addr=0x2000, dc_wdata=0x1234; mem_ready 2 cycles after mem_req.
- Response: mem_we=1, mem_wdata=0x1234; dc_rvalid with dc_rdata=0.
REQ-043 Simultaneous ic_req and dc_req, held, for three rounds.
- Without the macro: grant order DC, DC, DC while dc_req stays high.
- With MEM_ARB_RR_EN: grant order DC, IC, DC.
REQ-044 Reset asserted the cycle after dc_gnt.
- Response: mem_req=0 and busy=0 the next cycle; a later mem_ready produces no rvalid.
REQ-045 Back-to-back and stray-ready checks.
- mem_ready pulsed while IDLE -> no output change.
- ic_req dropped before grant while dc is being served -> no ic_gnt ever.
- Back-to-back ic requests -> exactly one IDLE cycle between rvalid and the next gnt.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between the icache and dcache.
// One transaction is outstanding at a time. Grants, completions and the memory
// request are all registered outputs.
// Optional feature: define MEM_ARB_RR_EN to break simultaneous-request ties
// round-robin; otherwise the dcache always wins a tie.
//
// state     | meaning
// S_IDLE    | no transaction; arbitrate any pending request
// S_BUSY_IC | icache fill in flight, waiting for mem_ready
// S_BUSY_DC | dcache fill or writeback in flight, waiting for mem_ready
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_rvalid,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_gnt,
  output logic              dc_rvalid,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IC = 2'd1;
  localparam logic [1:0] S_BUSY_DC = 2'd2;

  logic [1:0] state;
  logic       dc_wins;

`ifdef MEM_ARB_RR_EN
  // 1 = dcache owned the most recent grant; reset value makes dcache win the first tie
  logic last_dc;

  // Round-robin tie break: the requester not served last wins
  always_comb begin
    dc_wins = dc_req & (~ic_req | ~last_dc);
  end

  // Remember the owner of every grant issued from IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      last_dc <= 1'b0;
    end else if (state == S_IDLE && (ic_req || dc_req)) begin
      last_dc <= dc_wins;
    end
  end
`else
  // Fixed priority: a data stall freezes the whole pipe, so dcache always wins a tie
  always_comb begin
    dc_wins = dc_req;
  end
`endif

  // Transaction FSM with registered grant/completion pulses and memory port
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ic_gnt    <= 1'b0;
      dc_gnt    <= 1'b0;
      ic_rvalid <= 1'b0;
      dc_rvalid <= 1'b0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
    end else begin
      ic_gnt    <= 1'b0;
      dc_gnt    <= 1'b0;
      ic_rvalid <= 1'b0;
      dc_rvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ic_req || dc_req) begin
            state   <= dc_wins ? S_BUSY_DC : S_BUSY_IC;
            busy    <= 1'b1;
            mem_req <= 1'b1;
            if (dc_wins) begin
              mem_addr  <= dc_addr;
              mem_we    <= dc_we;
              mem_wdata <= dc_wdata;
              dc_gnt    <= 1'b1;
            end else begin
              mem_addr  <= ic_addr;
              mem_we    <= 1'b0;
              ic_gnt    <= 1'b1;
            end
          end
        end
        S_BUSY_IC: begin
          if (mem_ready) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            ic_rvalid <= 1'b1;
            ic_rdata  <= mem_rdata;
          end
        end
        S_BUSY_DC: begin
          if (mem_ready) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            dc_rvalid <= 1'b1;
            dc_rdata  <= mem_we ? '0 : mem_rdata;
          end
        end
        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized requester/memory
// traffic, every cycle compared against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req, dc_req, dc_we, mem_ready;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] dc_wdata, mem_rdata;
  logic          ic_gnt, ic_rvalid, dc_gnt, dc_rvalid, mem_req, mem_we, busy;
  logic [LW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
    .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Reference model: the one outstanding transaction plus the visible results
  bit            m_active;
  bit            m_is_dc;
  bit            m_last_dc;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [LW-1:0] m_wdata;
  logic          m_ic_gnt, m_dc_gnt, m_ic_rv, m_dc_rv;
  logic [LW-1:0] m_ic_rdata, m_dc_rdata;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge();
    bit take_dc;
    if (reset) begin
      m_active = 0; m_is_dc = 0; m_last_dc = 0; m_we = 0;
      m_ic_gnt = 0; m_dc_gnt = 0; m_ic_rv = 0; m_dc_rv = 0;
      m_ic_rdata = '0; m_dc_rdata = '0;
      return;
    end
    m_ic_gnt = 0; m_dc_gnt = 0; m_ic_rv = 0; m_dc_rv = 0;
    if (!m_active) begin
      if (ic_req || dc_req) begin
`ifdef MEM_ARB_RR_EN
        take_dc = (ic_req && dc_req) ? !m_last_dc : dc_req;
`else
        take_dc = dc_req;
`endif
        m_active  = 1;
        m_is_dc   = take_dc;
        m_last_dc = take_dc;
        m_addr    = take_dc ? dc_addr : ic_addr;
        m_we      = take_dc && dc_we;
        m_wdata   = dc_wdata;
        if (take_dc) m_dc_gnt = 1; else m_ic_gnt = 1;
      end
    end else if (mem_ready) begin
      m_active = 0;
      if (m_is_dc) begin
        m_dc_rv = 1;
        m_dc_rdata = m_we ? '0 : mem_rdata;
      end else begin
        m_ic_rv = 1;
        m_ic_rdata = mem_rdata;
      end
    end
  endfunction

  task automatic check_all();
    chk("busy", busy, m_active);
    chk("mem_req", mem_req, m_active);
    chk("ic_gnt", ic_gnt, m_ic_gnt);
    chk("dc_gnt", dc_gnt, m_dc_gnt);
    chk("ic_rvalid", ic_rvalid, m_ic_rv);
    chk("dc_rvalid", dc_rvalid, m_dc_rv);
    chk("ic_rdata", ic_rdata, m_ic_rdata);
    chk("dc_rdata", dc_rdata, m_dc_rdata);
    if (m_active) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  // Advance one clock: model consumes the inputs now driven, then DUT is sampled #1 after the edge
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom} | 128'h1;
  endfunction

  initial begin : main
    bit exp_dc [3];
    bit got_dc;
    int k;
`ifdef MEM_ARB_RR_EN
    exp_dc = '{1'b1, 1'b0, 1'b1};
`else
    exp_dc = '{1'b1, 1'b1, 1'b1};
`endif
    reset = 1; ic_req = 0; dc_req = 0; dc_we = 0; mem_ready = 0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
    #1;
    step(); step();
    reset = 0;
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // Single icache fill
    ic_req = 1; ic_addr = 32'h0000_1000;
    step();
    chk("ic1_gnt", ic_gnt, 1'b1);
    chk("ic1_mem_req_c1", mem_req, 1'b1);
    chk("ic1_addr", mem_addr, 128'h1000);
    chk("ic1_we", mem_we, 1'b0);
    ic_req = 0;
    step();
    chk("ic1_mem_req_c2", mem_req, 1'b1);
    step();
    chk("ic1_mem_req_c3", mem_req, 1'b1);
    mem_ready = 1; mem_rdata = {16{8'hA5}};
    step();
    mem_ready = 0;
    chk("ic1_rvalid", ic_rvalid, 1'b1);
    chk("ic1_rdata", ic_rdata, {16{8'hA5}});
    chk("ic1_mem_req_c4", mem_req, 1'b0);

    // Simultaneous held requests, three rounds
    ic_req = 1; ic_addr = 32'h0000_3000;
    dc_req = 1; dc_we = 0; dc_addr = 32'h0000_4000;
    for (int r = 0; r < 3; r++) begin
      k = 0;
      while (!(ic_gnt || dc_gnt) && k < 5) begin
        step();
        k++;
      end
      chk("tie_gnt_timeout", (ic_gnt || dc_gnt), 1'b1);
      got_dc = dc_gnt;
      chk("tie_order", got_dc, exp_dc[r]);
      mem_ready = 1; mem_rdata = rnd_line();
      step();
      mem_ready = 0;
    end
    ic_req = 0; dc_req = 0;
    step();

    // dcache writeback, ready two cycles after mem_req rises
    dc_req = 1; dc_we = 1; dc_addr = 32'h0000_2000; dc_wdata = 128'h1234;
    step();
    chk("wb_gnt", dc_gnt, 1'b1);
    chk("wb_we", mem_we, 1'b1);
    chk("wb_wdata", mem_wdata, 128'h1234);
    chk("wb_addr", mem_addr, 128'h2000);
    dc_req = 0; dc_we = 0;
    step();
    mem_ready = 1; mem_rdata = rnd_line();
    step();
    mem_ready = 0;
    chk("wb_rvalid", dc_rvalid, 1'b1);
    chk("wb_rdata", dc_rdata, '0);

    // Reset the cycle after dc_gnt aborts the fill
    dc_req = 1; dc_addr = 32'h0000_5000;
    step();
    chk("ab_gnt", dc_gnt, 1'b1);
    dc_req = 0; reset = 1;
    step();
    reset = 0;
    chk("ab_mem_req", mem_req, 1'b0);
    chk("ab_busy", busy, 1'b0);
    step();
    mem_ready = 1; mem_rdata = rnd_line();
    step();
    mem_ready = 0;
    chk("ab_no_rvalid", dc_rvalid, 1'b0);
    step();
    chk("ab_no_rvalid2", dc_rvalid, 1'b0);

    // Stray mem_ready while idle
    mem_ready = 1; mem_rdata = rnd_line();
    step();
    mem_ready = 0;
    chk("stray_ic_rv", ic_rvalid, 1'b0);
    chk("stray_dc_rv", dc_rvalid, 1'b0);
    chk("stray_ic_rdata", ic_rdata, '0);
    chk("stray_dc_rdata", dc_rdata, '0);
    chk("stray_busy", busy, 1'b0);

    // ic request abandoned while dc is being served
    dc_req = 1; dc_addr = 32'h0000_6000;
    step();
    chk("drop_dc_gnt", dc_gnt, 1'b1);
    dc_req = 0; ic_req = 1; ic_addr = 32'h0000_7000;
    step();
    ic_req = 0;
    mem_ready = 1; mem_rdata = rnd_line();
    step();
    mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk("drop_no_ic_gnt", ic_gnt, 1'b0);
      step();
    end

    // Back-to-back ic fills: new request raised after seeing rvalid
    ic_req = 1; ic_addr = 32'h0000_8000;
    step();
    chk("b2b_gnt1", ic_gnt, 1'b1);
    ic_req = 0; mem_ready = 1; mem_rdata = rnd_line();
    step();
    mem_ready = 0;
    chk("b2b_rvalid", ic_rvalid, 1'b1);
    step();
    chk("b2b_idle_busy", busy, 1'b0);
    chk("b2b_idle_gnt", ic_gnt, 1'b0);
    ic_req = 1; ic_addr = 32'h0000_8040;
    step();
    chk("b2b_gnt2", ic_gnt, 1'b1);
    ic_req = 0; mem_ready = 1;
    step();
    mem_ready = 0;

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      chk("gnt_excl", (ic_gnt && dc_gnt), 1'b0);
      chk("rv_excl", (ic_rvalid && dc_rvalid), 1'b0);
      reset = ($urandom_range(199) == 0);
      if (ic_gnt) ic_req = 0;
      else if (ic_req && $urandom_range(15) == 0) ic_req = 0;
      else if (!ic_req && $urandom_range(3) == 0) begin
        ic_req = 1; ic_addr = $urandom;
      end
      if (dc_gnt) dc_req = 0;
      else if (dc_req && $urandom_range(15) == 0) dc_req = 0;
      else if (!dc_req && $urandom_range(3) == 0) begin
        dc_req = 1; dc_we = $urandom_range(1) == 1;
        dc_addr = $urandom; dc_wdata = rnd_line();
      end
      mem_ready = ($urandom_range(2) == 0);
      mem_rdata = rnd_line();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
